famicom_pad_reader: RTL

//  Host-side (initiator) Famicom/NES serial controller reader. It drives latch
//  and pulse to an external pad, shifts in the 8 active-low button bits, and

---
 rtl/famicom_pad_reader_if.sv | 20 ++
 rtl/famicom_pad_reader.sv | 111 +++++++++++
 2 files changed

// File: rtl/famicom_pad_reader_if.sv
// Core/pad-facing signal bundle for the Famicom serial pad reader.
// The reader itself takes the slave view; the surrounding core or bench takes the master view.
interface famicom_pad_reader_if;
   logic       start;
   logic       pad_latch;
   logic       pad_pulse;
   logic       pad_data;
   logic [7:0] buttons;
   logic       valid;
   logic       busy;

   modport master (
      output start, pad_data,
      input  pad_latch, pad_pulse, buttons, valid, busy
   );
   modport slave (
      input  start, pad_data,
      output pad_latch, pad_pulse, buttons, valid, busy
   );
endinterface

// File: rtl/famicom_pad_reader.sv
// Host-side Famicom/NES pad reader: latches the pad, clocks out 8 active-low bits,
// and presents them as an active-high byte with a one-cycle valid strobe.
module famicom_pad_reader #(
   parameter int LATCH_CYCLES = 600,
   parameter int HALF_CYCLES  = 300,
   parameter int POLL_CYCLES  = 833333
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   famicom_pad_reader_if.slave  pad
);
   localparam int MAX_PH = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
   localparam int PW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
   localparam int TW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
   localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
   localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    buttons_q, buttons_d;
   logic [TW-1:0] poll_q, poll_d;
   logic [1:0]    sync_q, sync_d;
   logic          tick;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         buttons_q <= '0;
         poll_q    <= '0;
         sync_q    <= 2'b11;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         buttons_q <= buttons_d;
         poll_q    <= poll_d;
         sync_q    <= sync_d;
      end
   end

   // pad_data is asynchronous to clk_sys; sync_q[1] is the settled sample
   always_comb begin
      sync_d = {sync_q[0], pad.pad_data};
      tick   = (poll_q == POLL_LAST);
      poll_d = tick ? '0 : poll_q + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q + 1'b1;
      bit_d     = bit_q;
      shift_d   = shift_q;
      buttons_d = buttons_q;
      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (tick || pad.start) state_d = LATCH;
         end
         LATCH: begin
            if (phase_q == LATCH_LAST) begin
               phase_d = '0;
               bit_d   = '0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (phase_q == HALF_LAST) begin
               phase_d        = '0;
               shift_d[bit_q] = ~sync_q[1];
               // buttons load on DONE entry so they change in the valid cycle
               if (bit_q == 3'd7) begin
                  state_d   = DONE;
                  buttons_d = shift_d;
               end else begin
                  state_d = HIGH;
               end
            end
         end
         HIGH: begin
            if (phase_q == HALF_LAST) begin
               phase_d = '0;
               bit_d   = bit_q + 1'b1;
               state_d = LOW;
            end
         end
         DONE: begin
            phase_d = '0;
            state_d = IDLE;
         end
         default: begin
            phase_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign pad.pad_latch = (state_q == LATCH);
   assign pad.pad_pulse = (state_q == HIGH);
   assign pad.valid     = (state_q == DONE);
   assign pad.busy      = (state_q == LATCH) || (state_q == LOW) || (state_q == HIGH);
   assign pad.buttons   = buttons_q;
endmodule
